// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants for the multiplexed 7-segment scanner
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit hex value to active-low 7-segment glyph
module seg7_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] glyph_o
);

   assign glyph_o = GLYPH_TABLE[value_i];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 7-segment scanner with per-frame digit snapshot
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] snap_d_q, snap_d_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic [3:0] cur_digit;
   logic [6:0] cur_glyph;
   logic       digit_blank;

   assign cur_digit = snap_d_q[{idx_q, 2'b00} +: 4];

   seg7_decode u_decode (
      .value_i (cur_digit),
      .glyph_o (cur_glyph)
   );

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] blank;
   logic                  lead_zero;

   // Walk down from the most significant digit; digit 0 is never blanked.
   always_comb begin
      blank     = '0;
      lead_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lead_zero = lead_zero & (snap_d_q[4*i +: 4] == 4'h0);
         blank[i]  = lead_zero;
      end
   end

   assign digit_blank = blank[idx_q];
`else
   assign digit_blank = 1'b0;
`endif

   always_comb begin
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      snap_d_d  = snap_d_q;
      snap_dp_d = snap_dp_q;
      if (cnt_q == CNT_LAST) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         // Frame boundary: inputs are sampled once so a frame never tears.
         if (idx_q == IDX_LAST) begin
            snap_d_d  = digits_i;
            snap_dp_d = dp_i;
         end
      end

      an_d  = AN_OFF[NUM_DIGITS-1:0];
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      // cnt==0 is a dark guard cycle so the previous digit does not ghost.
      if (cnt_q != '0) begin
         an_d[idx_q] = 1'b0;
         seg_d       = digit_blank ? SEG_OFF : cur_glyph;
         dp_d        = ~snap_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         snap_d_q  <= '0;
         snap_dp_q <= '0;
         an_q      <= AN_OFF[NUM_DIGITS-1:0];
         seg_q     <= SEG_OFF;
         dp_q      <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         snap_d_q  <= snap_d_d;
         snap_dp_q <= snap_dp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;
   assign dp_o  = dp_q;

endmodule
